// File: rtl/mine_num_map_scanner_if.sv
// Purpose: bundles the scanner's control handshake, map input and deduce-unit link.
// Latency: none, wires only.
// Backpressure: none; start is a level sampled by the scanner only while idle.
interface mine_num_map_scanner_if #(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8
);
  localparam int NCELLS = MAP_WIDTH * MAP_HEIGHT;

  logic                  start_i;
  logic [NCELLS-1:0]     map_i;
  logic [NCELLS-1:0]     map_o;
  logic [2:0]            x_pos_o;
  logic [2:0]            y_pos_o;
  logic [7:0]            position_o;
  logic [3:0]            round_mine_num_i;
  logic                  busy_o;
  logic                  done_o;
  logic [4*NCELLS-1:0]   num_map_o;

  // Scanner side.
  modport slave (
    input  start_i, map_i, round_mine_num_i,
    output map_o, x_pos_o, y_pos_o, position_o, busy_o, done_o, num_map_o
  );

  // Game-control FSM plus deduce unit side.
  modport master (
    output start_i, map_i, round_mine_num_i,
    input  map_o, x_pos_o, y_pos_o, position_o, busy_o, done_o, num_map_o
  );
endinterface

// File: rtl/mine_num_map_scanner.sv
// Purpose: sweeps every map cell through deduce_mine_num and assembles the per-cell number map.
// Latency: done pulses MAP_WIDTH*MAP_HEIGHT+DEDUCE_LAT+1 cycles after start is accepted.
// Backpressure: none; start is ignored while busy or in DONE (no queuing).
module mine_num_map_scanner #(
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8,
  parameter int DEDUCE_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mine_num_map_scanner_if.slave  bus
);
  localparam int NCELLS = MAP_WIDTH * MAP_HEIGHT;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [NCELLS-1:0]              map_q, map_d;
  logic [2:0]                     x_q, x_d, y_q, y_d;
  logic [7:0]                     pos_q, pos_d;
  logic [4*NCELLS-1:0]            num_map_q, num_map_d;
  // Stage i holds the position issued i+1 cycles ago; the last stage lines up with the returned count.
  logic [DEDUCE_LAT-1:0]          pipe_vld_q, pipe_vld_d;
  logic [DEDUCE_LAT-1:0][7:0]     pipe_pos_q, pipe_pos_d;
  logic                           issue, last_pos, drain_last;
  logic                           cap_vld;
  logic [7:0]                     cap_pos;
  logic                           busy, done;

  assign issue    = (state_q == SCAN);
  assign last_pos = (pos_q == 8'(NCELLS - 1));
  assign cap_vld  = pipe_vld_q[DEDUCE_LAT-1];
  assign cap_pos  = pipe_pos_q[DEDUCE_LAT-1];

  // Pipe is empty after this edge when nothing but the capturing stage is still valid.
  always_comb begin
    drain_last = 1'b1;
    for (int i = 0; i < DEDUCE_LAT - 1; i++) begin
      if (pipe_vld_q[i]) drain_last = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = SCAN;
      SCAN:    if (last_pos)    state_d = DRAIN;
      DRAIN:   if (drain_last)  state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SCAN, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default:     ;
    endcase
  end

  // Datapath next-state: map latch, coordinate walk, issue pipe and result capture.
  always_comb begin
    map_d     = map_q;
    x_d       = x_q;
    y_d       = y_q;
    pos_d     = pos_q;
    num_map_d = num_map_q;

    if (state_q == IDLE && bus.start_i) begin
      map_d     = bus.map_i;
      num_map_d = '0;
      x_d       = '0;
      y_d       = '0;
      pos_d     = '0;
    end else if (state_q == SCAN && !last_pos) begin
      pos_d = pos_q + 8'd1;
      if (x_q == 3'(MAP_WIDTH - 1)) begin
        x_d = '0;
        y_d = y_q + 3'd1;
      end else begin
        x_d = x_q + 3'd1;
      end
    end

    pipe_vld_d[0] = issue;
    pipe_pos_d[0] = pos_q;
    for (int i = 1; i < DEDUCE_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_pos_d[i] = pipe_pos_q[i-1];
    end

    // Mines override whatever the deduce unit returns with the reserved marker.
    for (int c = 0; c < NCELLS; c++) begin
      if (cap_vld && cap_pos == 8'(c)) begin
        num_map_d[4*c +: 4] = map_q[c] ? 4'hF : bus.round_mine_num_i;
      end
    end
  end

  // Datapath registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      map_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pos_q      <= '0;
      num_map_q  <= '0;
      pipe_vld_q <= '0;
      pipe_pos_q <= '0;
    end else begin
      map_q      <= map_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pos_q      <= pos_d;
      num_map_q  <= num_map_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_pos_q <= pipe_pos_d;
    end
  end

  assign bus.map_o      = map_q;
  assign bus.x_pos_o    = x_q;
  assign bus.y_pos_o    = y_q;
  assign bus.position_o = pos_q;
  assign bus.num_map_o  = num_map_q;
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
endmodule

// File: tb/tb_mine_num_map_scanner.sv
// Purpose: directed, table-driven check of the map scanner against hand and reference values.
// Latency: a registered deduce_mine_num model (one cycle) answers the scanner's coordinates.
// Backpressure: none; every wait is a fixed cycle count.
module tb_mine_num_map_scanner;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mine_num_map_scanner_if #(.MAP_WIDTH(8), .MAP_HEIGHT(8)) bus ();

  mine_num_map_scanner #(.MAP_WIDTH(8), .MAP_HEIGHT(8), .DEDUCE_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0]  map;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [4];

  // Neighbour count of cell (x,y) in an 8x8 map.
  function automatic logic [3:0] nbr_count(input logic [63:0] m, input int x, input int y);
    int n;
    int xx, yy;
    n = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xx = x + dx;
        yy = y + dy;
        if (!(dx == 0 && dy == 0) && xx >= 0 && xx < 8 && yy >= 0 && yy < 8) begin
          if (m[yy*8 + xx]) n++;
        end
      end
    end
    return 4'(n);
  endfunction

  function automatic logic [255:0] ref_num_map(input logic [63:0] m);
    logic [255:0] r;
    r = '0;
    for (int p = 0; p < 64; p++) begin
      r[4*p +: 4] = m[p] ? 4'hF : nbr_count(m, p % 8, p / 8);
    end
    return r;
  endfunction

  // Stand-in for deduce_mine_num: registered count for the presented position.
  always @(posedge clk) begin
    bus.round_mine_num_i <= nbr_count(bus.map_o, int'(bus.position_o) % 8, int'(bus.position_o) / 8);
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full sweep from start through a few idle cycles after done.
  task automatic do_sweep(input logic [63:0] m, input logic [255:0] exp, input bit poke, input string tag);
    int busy_err, done_err, coord_err, hold_err, done_seen, p;
    busy_err = 0; done_err = 0; coord_err = 0; hold_err = 0; done_seen = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.map_i   = m;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.map_i   = ~m;
    chk({tag, " cleared_cycle1"}, bus.num_map_o, '0);
    chk({tag, " map_latched"}, 256'(bus.map_o), 256'(m));
    for (int c = 1; c <= 72; c++) begin
      p = (c - 1 > 63) ? 63 : c - 1;
      if (bus.busy_o !== (c <= 65)) busy_err++;
      if (bus.done_o !== (c == 66)) done_err++;
      if (bus.done_o === 1'b1) done_seen++;
      if (bus.position_o !== 8'(p) || bus.x_pos_o !== 3'(p % 8) || bus.y_pos_o !== 3'(p / 8))
        coord_err++;
      if (c == 66) chk({tag, " num_map_at_done"}, bus.num_map_o, exp);
      if (c > 66 && bus.num_map_o !== exp) hold_err++;
      bus.start_i = poke && (c == 20 || c == 66);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    chk({tag, " busy_window_bad_cycles"}, 256'(busy_err), '0);
    chk({tag, " done_window_bad_cycles"}, 256'(done_err), '0);
    chk({tag, " done_pulse_count"}, 256'(done_seen), 256'(1));
    chk({tag, " coord_seq_bad_cycles"}, 256'(coord_err), '0);
    chk({tag, " num_map_hold_bad_cycles"}, 256'(hold_err), '0);
    chk({tag, " map_held_after_done"}, 256'(bus.map_o), 256'(m));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, 256'(bus.busy_o), '0);
    chk({tag, " done"}, 256'(bus.done_o), '0);
    chk({tag, " map_o"}, 256'(bus.map_o), '0);
    chk({tag, " position"}, 256'({bus.y_pos_o, bus.x_pos_o, bus.position_o}), '0);
    chk({tag, " num_map"}, bus.num_map_o, '0);
  endtask

  initial begin
    int busy_seen, done_seen;
    logic [63:0] cplx;
    cplx = 64'h6fcb_9f0a_b100_9080;

    vecs[0] = '{map: 64'h0, exp: 256'h0};
    vecs[1] = '{map: {64{1'b1}}, exp: {64{4'hF}}};
    vecs[2] = '{map: 64'h0000_0000_0000_0200,
                exp: 256'h00000000_00000000_00000000_00000000_00000000_00000111_000001F1_00000111};
    vecs[3] = '{map: cplx, exp: ref_num_map(cplx)};

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.map_i   = 64'hDEAD_BEEF_0123_4567;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero("reset");
    // start low in IDLE: everything holds
    repeat (3) @(negedge clk);
    chk_all_zero("idle_hold");

    for (int i = 0; i < 4; i++) begin
      do_sweep(vecs[i].map, vecs[i].exp, (i == 3), $sformatf("vec%0d", i));
      if (i == 3) begin
        chk("vec3 nibble0_corner", 256'(bus.num_map_o[3:0]), 256'(4'h0));
        chk("vec3 nibble7_mine", 256'(bus.num_map_o[31:28]), 256'(4'hF));
      end
    end

    // New start with a different map after a poked sweep: result rebuilt from cleared state.
    do_sweep(vecs[2].map, vecs[2].exp, 1'b0, "restart");

    // Reset during cycle 30 of a sweep.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.map_i   = cplx;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clk);
    chk("midreset busy_before", 256'(bus.busy_o), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midreset");
    busy_seen = 0;
    done_seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (bus.busy_o === 1'b1) busy_seen++;
      if (bus.done_o === 1'b1) done_seen++;
      @(negedge clk);
    end
    chk("midreset no_done", 256'(done_seen), '0);
    chk("midreset no_busy", 256'(busy_seen), '0);
    chk("midreset num_map_stays0", bus.num_map_o, '0);

    do_sweep(vecs[1].map, vecs[1].exp, 1'b0, "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
